// File: rtl/booth_seq_multiplier.sv
// Sequential signed Booth multiplier, one recoding step per clock.
// RADIX4=0 retires one multiplier bit per step, RADIX4=1 retires two.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RADIX4 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned Iter  = (RADIX4 != 0) ? WIDTH / 2 : WIDTH;
  localparam int unsigned CntW  = $clog2(Iter + 1);
  // Guard bits so that -M (radix-2) and -2M (radix-4) never overflow the accumulator.
  localparam int unsigned AccW  = (RADIX4 != 0) ? WIDTH + 2 : WIDTH + 1;
  localparam int unsigned Shift = (RADIX4 != 0) ? 2 : 1;
  localparam int unsigned CatW  = AccW + WIDTH + 1;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e               state_q, state_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic signed [AccW-1:0] m_ext;
  logic signed [AccW-1:0] addend;
  logic signed [AccW-1:0] sum;
  logic signed [CatW-1:0] cat;
  logic signed [CatW-1:0] shifted;
  logic [AccW-1:0]        acc_shift;
  logic [WIDTH-1:0]       q_shift;
  logic                   q1_shift;

  // Booth recoding of the low multiplier bits plus the appended q_1 bit.
  always_comb begin
    m_ext  = {{(AccW - WIDTH){m_q[WIDTH-1]}}, m_q};
    addend = '0;
    if (RADIX4 != 0) begin
      case ({q_q[1], q_q[0], q1_q})
        3'b001, 3'b010: addend = m_ext;
        3'b011:         addend = m_ext <<< 1;
        3'b100:         addend = -(m_ext <<< 1);
        3'b101, 3'b110: addend = -m_ext;
        default:        addend = '0;
      endcase
    end else begin
      case ({q_q[0], q1_q})
        2'b01:   addend = m_ext;
        2'b10:   addend = -m_ext;
        default: addend = '0;
      endcase
    end
  end

  // Add and arithmetic shift of {A, Q, q_1} in the same cycle.
  always_comb begin
    sum       = $signed(acc_q) + addend;
    cat       = {sum, q_q, q1_q};
    shifted   = cat >>> Shift;
    acc_shift = shifted[CatW-1 -: AccW];
    q_shift   = shifted[WIDTH:1];
    q1_shift  = shifted[0];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          q_d     = multiplier;
          q1_d    = 1'b0;
          m_d     = multiplicand;
          cnt_d   = CntW'(Iter);
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_shift;
        q_d   = q_shift;
        q1_d  = q1_shift;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          product_d = {acc_shift[WIDTH-1:0], q_shift};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: four instances (8/32 bit, radix-2/4) checked
// against plain signed multiplication.
module tb_booth_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [4];
  logic [31:0] mc [4];
  logic [31:0] mq [4];
  logic        busy_s [4];
  logic        done_s [4];
  logic [63:0] prod [4];
  logic [15:0] p8a, p8b;
  logic [63:0] p32a, p32b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier #(.WIDTH(8), .RADIX4(0)) u_w8_r2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .multiplicand(mc[0][7:0]),
    .multiplier(mq[0][7:0]), .busy(busy_s[0]), .done(done_s[0]), .product(p8a)
  );
  booth_seq_multiplier #(.WIDTH(8), .RADIX4(1)) u_w8_r4 (
    .clk(clk), .rst(rst), .start(start_s[1]), .multiplicand(mc[1][7:0]),
    .multiplier(mq[1][7:0]), .busy(busy_s[1]), .done(done_s[1]), .product(p8b)
  );
  booth_seq_multiplier #(.WIDTH(32), .RADIX4(0)) u_w32_r2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .multiplicand(mc[2]),
    .multiplier(mq[2]), .busy(busy_s[2]), .done(done_s[2]), .product(p32a)
  );
  booth_seq_multiplier #(.WIDTH(32), .RADIX4(1)) u_w32_r4 (
    .clk(clk), .rst(rst), .start(start_s[3]), .multiplicand(mc[3]),
    .multiplier(mq[3]), .busy(busy_s[3]), .done(done_s[3]), .product(p32b)
  );

  assign prod[0] = {48'h0, p8a};
  assign prod[1] = {48'h0, p8b};
  assign prod[2] = p32a;
  assign prod[3] = p32b;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int iter_of(input int inst);
    case (inst)
      0:       return 8;
      1:       return 4;
      2:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] ref_product(input int inst, input longint m, input longint q);
    logic [63:0] p;
    p = m * q;
    if (inst < 2) p = p & 64'hFFFF;
    return p;
  endfunction

  // Full transaction: start, wait for done with a bound, check timing and result.
  task automatic do_mul(input int inst, input longint m, input longint q, input string tag);
    int iter = iter_of(inst);
    int edges = 0;
    int busy_cnt = 0;
    bit got = 1'b0;
    mc[inst]      = m[31:0];
    mq[inst]      = q[31:0];
    start_s[inst] = 1'b1;
    @(posedge clk); #1;
    start_s[inst] = 1'b0;
    while (!got && edges < iter + 8) begin
      if (busy_s[inst]) busy_cnt++;
      @(posedge clk); #1;
      edges++;
      if (done_s[inst]) got = 1'b1;
    end
    check_eq({tag, " done seen"}, 64'(got), 64'd1);
    check_eq({tag, " latency"}, 64'(edges + 1), 64'(iter + 1));
    check_eq({tag, " busy cycles"}, 64'(busy_cnt), 64'(iter));
    check_eq({tag, " product"}, prod[inst], ref_product(inst, m, q));
    @(posedge clk); #1;
    check_eq({tag, " done pulse width"}, 64'(done_s[inst]), 64'd0);
  endtask

  task automatic wait_done(input int inst, input int bound, output int edges, output int ndone);
    edges = 0;
    ndone = 0;
    while (ndone == 0 && edges < bound) begin
      @(posedge clk); #1;
      edges++;
      if (done_s[inst]) ndone++;
    end
  endtask

  initial begin
    longint corner [5];
    int edges, ndone, r1, r2;
    longint m, q;

    corner[0] = 0;
    corner[1] = 1;
    corner[2] = -1;
    corner[3] = 64'sd2147483647;
    corner[4] = -64'sd2147483648;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      mc[i] = '0;
      mq[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("reset busy %0d", i), 64'(busy_s[i]), 64'd0);
      check_eq($sformatf("reset done %0d", i), 64'(done_s[i]), 64'd0);
      check_eq($sformatf("reset product %0d", i), prod[i], 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed 8-bit cases, radix-2 then radix-4.
    do_mul(0, 3, -4, "r2 3*-4");
    check_eq("r2 3*-4 literal", prod[0], 64'hFFF4);
    do_mul(0, -128, -128, "r2 -128*-128");
    check_eq("r2 -128*-128 literal", prod[0], 64'h4000);
    do_mul(0, 127, -128, "r2 127*-128");
    check_eq("r2 127*-128 literal", prod[0], 64'hC080);
    do_mul(1, -7, 5, "r4 -7*5");
    check_eq("r4 -7*5 literal", prod[1], 64'hFFDD);
    do_mul(1, -128, -128, "r4 -128*-128");
    check_eq("r4 -128*-128 literal", prod[1], 64'h4000);

    // Start during busy must be ignored; start in the done cycle is accepted.
    mc[0] = 32'd5; mq[0] = 32'd6; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mc[0] = 32'd9; mq[0] = 32'd9; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_done(0, 20, edges, ndone);
    check_eq("ignored start: done pulses", 64'(ndone), 64'd1);
    check_eq("ignored start: latency", 64'(edges + 3 + 1), 64'd9);
    check_eq("ignored start: product", prod[0], 64'h001E);
    mc[0] = 32'hFFFF_FFFF; mq[0] = 32'hFFFF_FFFF; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    check_eq("b2b accepted busy", 64'(busy_s[0]), 64'd1);
    check_eq("b2b done dropped", 64'(done_s[0]), 64'd0);
    wait_done(0, 20, edges, ndone);
    check_eq("b2b done pulses", 64'(ndone), 64'd1);
    check_eq("b2b latency", 64'(edges + 1), 64'd9);
    check_eq("b2b product", prod[0], 64'h0001);

    // Reset during step 3 aborts with no done pulse and clears product.
    @(posedge clk); #1;
    mc[0] = 32'd10; mq[0] = 32'd10; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort busy", 64'(busy_s[0]), 64'd0);
    check_eq("abort done", 64'(done_s[0]), 64'd0);
    check_eq("abort product", prod[0], 64'd0);
    wait_done(0, 15, edges, ndone);
    check_eq("abort no later done", 64'(ndone), 64'd0);

    // Reset and start on the same edge: reset wins.
    mc[0] = 32'd3; mq[0] = 32'd3; start_s[0] = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; rst = 1'b0;
    check_eq("rst+start busy", 64'(busy_s[0]), 64'd0);
    wait_done(0, 12, edges, ndone);
    check_eq("rst+start no done", 64'(ndone), 64'd0);

    // 32-bit corner combinations and random operands in both modes.
    for (int inst = 2; inst < 4; inst++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          do_mul(inst, corner[i], corner[j], $sformatf("w32 inst%0d corner %0d,%0d", inst, i, j));
        end
      end
      for (int n = 0; n < 1000; n++) begin
        r1 = $urandom();
        r2 = $urandom();
        m  = r1;
        q  = r2;
        do_mul(inst, m, q, $sformatf("w32 inst%0d rand %0d (%0d*%0d)", inst, n, m, q));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Parametrised sequential Booth multiplier: signed two's-complement WIDTH x WIDTH -> 2*WIDTH product, computed one recoding step per clock. RADIX4 selects radix-2 (one bit per step) or radix-4 (two bits per step) recoding. It generalises the 2-bit q1q0 Booth decode into a complete start/busy/done multiplier for the MIPS pipeline's multiply path. The EX stage stalls on busy and captures product on done.

## Interface
- WIDTH, 32: operand width in bits; must be at least 4, and even when RADIX4=1.
- RADIX4, 0: 0 = radix-2 Booth, WIDTH steps; 1 = radix-4 modified Booth, WIDTH/2 steps.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  WIDTH  signed M; captured on the accepted start.
- multiplier  in  WIDTH  signed Q; captured on the accepted start.
- busy  out  1  high from the edge after an accepted start until completion.
- done  out  1  one-cycle pulse; product is valid from this cycle.
- product  out  2*WIDTH  signed M*Q; holds its value until the next completion.

## Operation
- Internal state:
  - Accumulator A: WIDTH+1 bits for radix-2, WIDTH+2 bits for radix-4, so that -M and -2M never overflow.
  - Shift register Q (WIDTH bits), appended bit q_1, registered M.
  - Step counter (ceil(log2(ITER+1)) bits), where ITER = WIDTH for radix-2 and WIDTH/2 for radix-4.
- FSM states are IDLE and RUN.
- IDLE:
  - If start=1: A=0, Q=multiplier, q_1=0, M=multiplicand, count=ITER, busy=1, go to RUN.
  - Otherwise hold.
- RUN, one step per cycle:
  - Radix-2: decode {Q[0], q_1}.
    - 00 or 11: no operation.
    - 01: A = A + sext(M).
    - 10: A = A - sext(M).
    - Then arithmetic right shift of {A, Q, q_1} by 1.
  - Radix-4: decode {Q[1], Q[0], q_1}.
    - 000 or 111: 0.
    - 001 or 010: +M.
    - 011: +2M.
    - 100: -2M.
    - 101 or 110: -M.
    - Then arithmetic right shift of {A, Q, q_1} by 2.
  - Add/subtract and shift happen in the same cycle; count decrements by 1.
  - On the step where count reaches 0:
    - product <= {A[WIDTH-1:0], Q} after that step's shift.
    - done <= 1, busy <= 0, go to IDLE.
- start while busy=1 is ignored; operands are not re-sampled.
- done stays low in every cycle except the single completion cycle.
- All arithmetic is signed two's complement. Results are exact for every operand pair, including M = Q = -2^(WIDTH-1), whose product is +2^(2*WIDTH-2).

## Timing
- Reset values: busy=0, done=0, product=0, FSM=IDLE, A=0, Q=0, q_1=0, count=0.
- Let start be accepted on edge k:
  - busy=1 after edge k.
  - Steps execute on edges k+1 through k+ITER.
  - After edge k+ITER: done=1, busy=0, product valid.
  - After edge k+ITER+1: done=0.
- Latency from start to done is ITER+1 cycles: 33 for WIDTH=32 radix-2, 17 for radix-4.
- Back-to-back: start asserted in the done cycle is accepted, since the FSM is already in IDLE. Throughput is one product per ITER+1 cycles.
- rst=1 on any edge, including mid-RUN, forces the reset values. The in-flight operation is aborted with no done pulse, and product clears to 0.
- rst and start high on the same edge: reset wins and start is dropped.

## Test plan
- WIDTH=8, RADIX4=0; start with M=3, Q=-4 -> done exactly 9 cycles after the start edge, product=16'hFFF4 (-12), busy high for exactly 8 cycles.
- WIDTH=8, RADIX4=0; M=-128, Q=-128 -> product=16'h4000 (+16384). Also M=127, Q=-128 -> product=16'hC080 (-16256).
- WIDTH=8, RADIX4=1; M=-7, Q=5 -> done 5 cycles after start, product=16'hFFDD (-35). Also M=-128, Q=-128 -> 16'h4000.
- Start with M=5, Q=6; pulse start again with M=9, Q=9 during busy -> second request ignored, product=16'h001E (30), one done pulse only. Then assert start in the done cycle with M=-1, Q=-1 -> accepted, next product=16'h0001.
- Assert rst for 1 cycle in step 3 of M=10, Q=10 -> busy=0, done=0, product=0 on the next cycle, and no done pulse follows.
- WIDTH=32 in both modes: 1000 random signed operand pairs plus all combinations of {0, 1, -1, 2^31-1, -2^31} -> product matches the reference model's M*Q, with latency 33 (radix-2) or 17 (radix-4).
